// File: rtl/pipeline_if_prefetch_pkg.sv
// pipeline_if_prefetch_pkg: opcode constants, bubble value and control-transfer decode for the IF stage
package pipeline_if_prefetch_pkg;

    localparam logic [6:0]  OPC_JAL     = 7'b1101111;
    localparam logic [6:0]  OPC_JALR    = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;
    localparam logic [31:0] INST_BUBBLE = 32'h0000_0000;

    function automatic logic is_ctrl_xfer(input logic [6:0] opc);
        return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/pipeline_if_prefetch_fifo.sv
// if_fifo: synchronous prefetch queue with clear; dout shows the head entry combinationally
module if_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clr_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;

    // storage array; a clear discards the same-cycle write
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= din_i;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

endmodule

// File: rtl/pipeline_if_prefetch.sv
// pipeline_if_prefetch: IF stage that prefetches into a small queue, flushes on redirect and can halt after branches
module pipeline_if_prefetch
    import pipeline_if_prefetch_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                INST_W      = 32,
    parameter int                DEPTH       = 4,
    parameter int                BRANCH_WAIT = 1,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_re_o,
    input  logic              ram_busy_i,
    input  logic              ram_done_i,
    input  logic [INST_W-1:0] ram_data_i
);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d, pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              outstanding_q, outstanding_d, discard_q, discard_d, hold_q, hold_d;
    logic              push, pop, clr, fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [ADDR_W+INST_W-1:0] fifo_dout;

    // a request is withheld during a redirect so no wrong-path read is ever accepted
    assign ram_re_o   = rdy && !ram_busy_i && !outstanding_q && !hold_q && !redirect_i && !fifo_full
                        && ((fifo_count + CW'(outstanding_q)) < CW'(DEPTH));
    assign push       = rdy && ram_done_i && !discard_q && !redirect_i;
    assign pop        = rdy && !stall_i && !fifo_empty && !redirect_i;
    assign clr        = rdy && redirect_i;
    assign stall_o    = fifo_empty;
    assign ram_addr_o = fetch_pc_q;
    assign pc_o       = pc_q;
    assign inst_o     = inst_q;

    if_fifo #(.WIDTH(ADDR_W + INST_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .clr_i   (clr),
        .din_i   ({req_pc_q, ram_data_i}),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // next state: request/response bookkeeping, output pop, then redirect overrides
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        hold_d        = hold_q;
        if (rdy) begin
            outstanding_d = outstanding_q && !ram_done_i;
            discard_d     = discard_q && !ram_done_i;
            if (ram_re_o) begin
                outstanding_d = 1'b1;
                req_pc_d      = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
            end
            if (push && BRANCH_WAIT != 0 && is_ctrl_xfer(ram_data_i[6:0])) hold_d = 1'b1;
            if (pop) {pc_d, inst_d} = fifo_dout;
            else if (!stall_i) inst_d = INST_W'(INST_BUBBLE);
            if (redirect_i) begin
                fetch_pc_d = redirect_pc_i;
                hold_d     = 1'b0;
                inst_d     = INST_W'(INST_BUBBLE);
                discard_d  = outstanding_q && !ram_done_i;
            end
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            pc_q          <= '0;
            inst_q        <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            hold_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            hold_q        <= hold_d;
        end
    end

endmodule

// File: tb/tb_pipeline_if_prefetch.sv
// tb_pipeline_if_prefetch: directed scenarios checked every cycle against a queue-level model of the IF stage
module tb_pipeline_if_prefetch;

    logic        clk = 1'b0;
    logic        rst_n, rdy, stall_i, redirect_i, ram_busy_i, ram_done_i;
    logic [31:0] redirect_pc_i, ram_data_i, pc_o, inst_o, ram_addr_o;
    logic        stall_o, ram_re_o;

    pipeline_if_prefetch dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .pc_o(pc_o), .inst_o(inst_o), .stall_o(stall_o),
        .ram_addr_o(ram_addr_o), .ram_re_o(ram_re_o),
        .ram_busy_i(ram_busy_i), .ram_done_i(ram_done_i), .ram_data_i(ram_data_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_fpc, m_req, m_pc, m_inst;
    bit          m_out, m_disc, m_hold;
    bit          r_pend;
    logic [31:0] r_addr, branch_addr;
    int          r_cnt, lat;
    int          ncmp = 0, nerr = 0, nreads = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == branch_addr) ? 32'h0000_0063 : {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rdy = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        ram_busy_i = 1'b0; ram_done_i = 1'b0; ram_data_i = '0;
        mq.delete(); m_fpc = 0; m_req = 0; m_pc = 0; m_inst = 0;
        m_out = 0; m_disc = 0; m_hold = 0; r_pend = 0; r_cnt = 0;
        @(negedge clk); @(negedge clk);
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_inst", inst_o, 32'h0);
        chk("reset_addr", ram_addr_o, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic step();
        bit   done, m_re;
        ent_t e;
        done = r_pend && r_cnt == 0 && rdy;
        ram_done_i = done;
        ram_data_i = done ? word(r_addr) : 32'hDEAD_BEEF;
        #1;
        m_re = rdy && !ram_busy_i && !m_out && !m_hold && !redirect_i && (mq.size() + int'(m_out) < 4);
        chk("ram_re", ram_re_o, m_re);
        chk("ram_addr", ram_addr_o, m_fpc);
        chk("stall_o", stall_o, mq.size() == 0);
        chk("pc_o", pc_o, m_pc);
        chk("inst_o", inst_o, m_inst);
        if (ram_re_o) nreads++;
        if (rdy) begin
            if (redirect_i) begin
                mq.delete();
                m_inst = 0;
                m_disc = m_out && !done;
                m_out  = m_out && !done;
                m_fpc  = redirect_pc_i;
                m_hold = 0;
            end else begin
                if (!stall_i) begin
                    if (mq.size() > 0) begin
                        e = mq.pop_front();
                        m_pc = e.pc; m_inst = e.inst;
                    end else m_inst = 0;
                end
                if (done) begin
                    if (m_disc) m_disc = 0;
                    else begin
                        mq.push_back('{m_req, ram_data_i});
                        if (ram_data_i[6:0] inside {7'h6F, 7'h67, 7'h63}) m_hold = 1;
                    end
                    m_out = 0;
                end
                if (m_re) begin
                    m_out = 1; m_req = m_fpc; m_fpc = m_fpc + 4;
                end
            end
            if (done) r_pend = 0;
            else if (r_pend && r_cnt > 0) r_cnt--;
            if (m_re) begin
                r_pend = 1; r_addr = ram_addr_o; r_cnt = lat - 1;
            end
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic first_out(input int n, output logic [31:0] fpc, output logic [31:0] finst);
        fpc = 32'hFFFF_FFFF; finst = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            step();
            if (inst_o != 0 && finst == 32'hFFFF_FFFF) begin fpc = pc_o; finst = inst_o; end
        end
    endtask

    initial begin
        int          n0;
        logic [31:0] fp, fi;
        branch_addr = 32'hFFFF_FFFF;
        lat = 1;
        // 1: streaming with single-cycle RAM
        do_reset();
        steps(3);
        chk("s1_inst0", inst_o, 32'h0000_0013);
        chk("s1_pc0", pc_o, 32'h0);
        steps(2);
        chk("s1_inst1", inst_o, 32'h0000_0413);
        chk("s1_pc1", pc_o, 32'h4);
        ram_busy_i = 1'b1; steps(2); ram_busy_i = 1'b0;
        steps(6);
        // 2: stalled pipeline fills the queue, then drains back to back
        do_reset();
        stall_i = 1'b1; n0 = nreads;
        steps(10);
        chk("s2_reads", nreads - n0, 4);
        chk("s2_addr", ram_addr_o, 32'h10);
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s2_pc", pc_o, 32'(i * 4));
            chk("s2_inst", inst_o, 32'((i * 4) << 8) | 32'h13);
        end
        steps(4);
        // 3: branch halts fetch until redirect
        do_reset();
        branch_addr = 32'h8; n0 = nreads;
        steps(12);
        chk("s3_reads", nreads - n0, 3);
        chk("s3_addr_held", ram_addr_o, 32'hC);
        redirect_i = 1'b1; redirect_pc_i = 32'h40; step(); redirect_i = 1'b0;
        chk("s3_redir_addr", ram_addr_o, 32'h40);
        chk("s3_bubble", inst_o, 32'h0);
        steps(3);
        chk("s3_pc", pc_o, 32'h40);
        chk("s3_inst", inst_o, 32'h0000_4013);
        branch_addr = 32'hFFFF_FFFF;
        // 4: redirect while a slow read is in flight
        do_reset();
        lat = 3;
        for (int i = 0; i < 40 && !(m_out && m_req == 32'h10); i++) step();
        chk("s4_reach", ram_addr_o, 32'h14);
        redirect_i = 1'b1; redirect_pc_i = 32'h80; step(); redirect_i = 1'b0;
        first_out(12, fp, fi);
        chk("s4_first_pc", fp, 32'h80);
        chk("s4_first_inst", fi, 32'h0000_8013);
        // 5: redirect coincides with the response
        do_reset();
        lat = 1;
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'h100; step(); redirect_i = 1'b0;
        chk("s5_addr", ram_addr_o, 32'h100);
        first_out(8, fp, fi);
        chk("s5_first_pc", fp, 32'h100);
        chk("s5_first_inst", fi, 32'h0001_0013);
        // 6: global freeze mid-stream
        do_reset();
        lat = 2;
        steps(7);
        rdy = 1'b0; n0 = nreads;
        steps(3);
        chk("s6_frozen_reads", nreads - n0, 0);
        rdy = 1'b1;
        steps(8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
